// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fulladder.sv
// rtl/serial_adder_fulladder.sv - one-bit full adder built from two half-adder stages
module FULLADDERUSINGHALFADDER (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic hs_sum;
  logic hs_carry;
  logic hc_carry;

  assign hs_sum   = a ^ b;
  assign hs_carry = a & b;
  assign sum      = hs_sum ^ cin;
  assign hc_carry = hs_sum & cin;
  assign carry    = hs_carry | hc_carry;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, one full-adder cell per cycle
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fa_sum;
  logic             fa_carry;

  FULLADDERUSINGHALFADDER u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .cin   (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        // New sum bit enters at the MSB so the LSB-first stream lands in order.
        sum_sh_d = WIDTH'({fa_sum, sum_sh_q} >> 1);
        carry_d  = fa_carry;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = sum_sh_d;
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder at WIDTH=8 and WIDTH=1
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst8, start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       rst1, start1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Transaction-level model: an accepted add keeps the unit busy for WIDTH+1
  // cycles, the last of which is the done cycle carrying a+b+cin.
  int m_left[2];
  int m_pend[2];
  int m_res[2];
  int widths[2] = '{8, 1};

  always @(posedge clk) begin
    bit r[2];
    bit s[2];
    int tot[2];
    r[0] = rst8;   s[0] = start8; tot[0] = int'(a8) + int'(b8) + int'(cin8);
    r[1] = rst1;   s[1] = start1; tot[1] = int'(a1) + int'(b1) + int'(cin1);
    for (int k = 0; k < 2; k++) begin
      if (r[k]) begin
        m_left[k] = 0;
        m_res[k]  = 0;
      end else if (m_left[k] == 0) begin
        if (s[k]) begin
          m_left[k] = widths[k] + 1;
          m_pend[k] = tot[k];
        end
      end else begin
        m_left[k]--;
        if (m_left[k] == 1) m_res[k] = m_pend[k];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy8", int'(busy8), int'(m_left[0] > 0));
      chk("done8", int'(done8), int'(m_left[0] == 1));
      chk("res8",  int'({cout8, sum8}), m_res[0]);
      chk("busy1", int'(busy1), int'(m_left[1] > 0));
      chk("done1", int'(done1), int'(m_left[1] == 1));
      chk("res1",  int'({cout1, sum1}), m_res[1]);
    end
  end

  int done1_cyc[$];
  int done1_res[$];
  int cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (chk_en && done1) begin
      done1_cyc.push_back(cyc);
      done1_res.push_back(int'({cout1, sum1}));
    end
  end

  // Issue one add on the WIDTH=8 unit; inputs are zeroed right after accept.
  // Optional side actions: a second start at cycle 3, or a reset at cycle 4.
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input int exp_res, input bit restart, input bit abort);
    int n;
    int dones;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    n = 0;
    dones = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("busy_after_accept", int'(busy8), 1);
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      end
      if (restart && n == 3) begin
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1;
      end
      if (restart && n == 4) start8 = 1'b0;
      if (abort && n == 4) rst8 = 1'b1;
      if (abort && n == 5) begin
        rst8 = 1'b0;
        chk("abort_busy", int'(busy8), 0);
        chk("abort_res",  int'({cout8, sum8}), 0);
      end
      if (done8) begin
        dones++;
        chk("latency8", n, 9);
        chk("result8", int'({cout8, sum8}), exp_res);
      end
    end
    chk("done_count8", dones, abort ? 0 : 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy8", int'(busy8), 0);
    chk("reset_done8", int'(done8), 0);
    chk("reset_res8",  int'({cout8, sum8}), 0);
    chk("reset_busy1", int'(busy1), 0);
    rst8 = 1'b0; rst1 = 1'b0;

    add8(8'h00, 8'h00, 1'b0, 9'h000, 1'b0, 1'b0);
    add8(8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1'b0);
    add8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b0, 1'b0);
    add8(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b0, 1'b0);
    add8(8'h3C, 8'h0F, 1'b1, 9'h04C, 1'b1, 1'b0);
    add8(8'h12, 8'h34, 1'b0, 9'h046, 1'b0, 1'b1);
    add8(8'hC8, 8'h64, 1'b1, 9'h12D, 1'b0, 1'b0);

    // WIDTH=1: all eight {a,b,cin} with start held high throughout.
    start1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      int w;
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      w = 0;
      while (busy1 && w < 10) begin @(negedge clk); w++; end
      while (!busy1 && w < 10) begin @(negedge clk); w++; end
      chk("accept_wait1", int'(w < 10), 1);
      if (i == 7) start1 = 1'b0;
    end
    repeat (6) @(negedge clk);

    chk("done_count1", done1_res.size(), 8);
    for (int i = 0; i < 8 && i < done1_res.size(); i++) begin
      chk($sformatf("truth1_%0d", i), done1_res[i], ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1));
      if (i > 0) chk($sformatf("gap1_%0d", i), done1_cyc[i] - done1_cyc[i-1], 3);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
